// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_addsub_core.sv
// Combinational adder/subtractor shared by ADD, SUB and SLT.
module alu_addsub_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   full_s;

  assign b_eff_s = sub_i ? ~b_i : b_i;
  assign full_s  = {1'b0, a_i} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_i};
  assign sum_o   = full_s[WIDTH-1:0];
  assign cout_o  = full_s[WIDTH];
  // Overflow: effective operands agree in sign but the sum does not.
  assign ovf_o   = (a_i[WIDTH-1] == b_eff_s[WIDTH-1]) & (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus an iterative shift-add MUL,
// with registered result/NZCV flags behind valid/ready handshakes.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   acc_sum_s;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic                 out_valid_q, out_valid_d;
  logic                 accept_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 cout_s;
  logic                 ovf_s;
  logic [WIDTH-1:0]     alu_res_s;
  logic                 alu_c_s;
  logic                 alu_v_s;

  alu_addsub_core #(.WIDTH(WIDTH)) u_addsub (
    .a_i    (a),
    .b_i    (b),
    .sub_i  ((op == OP_SUB) | (op == OP_SLT)),
    .sum_o  (sum_s),
    .cout_o (cout_s),
    .ovf_o  (ovf_s)
  );

  // Gated by rst_n so upstream sees no acceptance while reset is asserted.
  assign in_ready  = rst_n & (state_q == S_IDLE) & (~out_valid_q | out_ready);
  assign accept_s  = in_valid & in_ready;
  assign busy      = (state_q == S_MUL);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

  // Single-cycle operation result and carry/overflow.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (op)
      OP_AND: alu_res_s = a & b;
      OP_OR:  alu_res_s = a | b;
      OP_XOR: alu_res_s = a ^ b;
      OP_ADD, OP_SUB: begin
        alu_res_s = sum_s;
        alu_c_s   = cout_s;
        alu_v_s   = ovf_s;
      end
      OP_SLT: begin
        alu_res_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
        alu_c_s   = cout_s;
        alu_v_s   = ovf_s;
      end
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM next-state, multiplier datapath and output-register update.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q & ~out_ready;
    case (state_q)
      S_IDLE: begin
        if (accept_s && (op == OP_MUL)) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = {(2*WIDTH){1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          state_d  = S_MUL;
        end else if (accept_s) begin
          result_d       = alu_res_s;
          flags_d[FLG_N] = alu_res_s[WIDTH-1];
          flags_d[FLG_Z] = (alu_res_s == {WIDTH{1'b0}});
          flags_d[FLG_C] = alu_c_s;
          flags_d[FLG_V] = alu_v_s;
          out_valid_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = acc_sum_s;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          result_d       = acc_sum_s[WIDTH-1:0];
          flags_d[FLG_N] = acc_sum_s[WIDTH-1];
          flags_d[FLG_Z] = (acc_sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
          flags_d[FLG_C] = 1'b0;
          flags_d[FLG_V] = |acc_sum_s[2*WIDTH-1:WIDTH];
          out_valid_d    = 1'b1;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= {(2*WIDTH){1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      acc_q       <= {(2*WIDTH){1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a 32-bit and an 8-bit instance driven side by side.
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [67:0] sb32[$];
  logic [67:0] sb8[$];
  logic [67:0] exp_v;

  logic        rst_n32 = 1'b0, iv32 = 1'b0, ordy32 = 1'b1;
  logic        ir32, ov32, busy32;
  logic [2:0]  op32 = 3'b000;
  logic [31:0] a32 = 32'd0, b32 = 32'd0, res32;
  logic [3:0]  fl32;

  logic        rst_n8 = 1'b0, iv8 = 1'b0, ordy8 = 1'b1;
  logic        ir8, ov8, busy8;
  logic [2:0]  op8 = 3'b000;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0, res8;
  logic [3:0]  fl8;

  alu_mc #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n32), .in_valid(iv32), .in_ready(ir32), .op(op32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(ordy32), .result(res32),
    .flags(fl32), .busy(busy32));

  alu_mc #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .in_valid(iv8), .in_ready(ir8), .op(op8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(ordy8), .result(res8),
    .flags(fl8), .busy(busy8));

  // Reference model: returns {N,Z,C,V, result[63:0]} for a w-bit ALU.
  function automatic logic [67:0] model(input int w, input logic [2:0] mop,
                                        input logic [63:0] ma, input logic [63:0] mb);
    logic [127:0] mask, av, bv, s, p;
    logic [63:0]  r;
    logic         c, v, lt;
    mask = (128'd1 << w) - 128'd1;
    av = {64'd0, ma} & mask;
    bv = {64'd0, mb} & mask;
    r = 64'd0; c = 1'b0; v = 1'b0;
    case (mop)
      OP_AND: r = av[63:0] & bv[63:0];
      OP_OR:  r = av[63:0] | bv[63:0];
      OP_XOR: r = av[63:0] ^ bv[63:0];
      OP_ADD: begin
        s = av + bv; r = s[63:0] & mask[63:0]; c = s[w];
        v = (av[w-1] == bv[w-1]) && (r[w-1] != av[w-1]);
      end
      OP_SUB, OP_SLT: begin
        s = av + (~bv & mask) + 128'd1; r = s[63:0] & mask[63:0]; c = s[w];
        v = (av[w-1] != bv[w-1]) && (r[w-1] != av[w-1]);
        if (mop == OP_SLT) begin
          lt = (av[w-1] != bv[w-1]) ? av[w-1] : (av < bv);
          r = {63'd0, lt};
        end
      end
      OP_MUL: begin
        p = av * bv; r = p[63:0] & mask[63:0]; v = |(p >> w);
      end
      default: r = 64'd0;
    endcase
    return {r[w-1], (r == 64'd0), c, v, r};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (ir32 !== 1'b0 || ir8 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b/%b want 0/0", ir32, ir8); end
    checks++; if (ov32 !== 1'b0 || ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b/%b want 0/0", ov32, ov8); end
    checks++; if (res32 !== 32'd0 || fl32 !== 4'd0 || busy32 !== 1'b0) begin errors++; $display("FAIL reset_state32: got res=%h fl=%b busy=%b want 0", res32, fl32, busy32); end
    checks++; if (res8 !== 8'd0 || fl8 !== 4'd0 || busy8 !== 1'b0) begin errors++; $display("FAIL reset_state8: got res=%h fl=%b busy=%b want 0", res8, fl8, busy8); end
    rst_n32 = 1'b1; rst_n8 = 1'b1;
    @(negedge clk);
    checks++; if (ir32 !== 1'b1 || ir8 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b/%b want 1/1", ir32, ir8); end
  endtask

  task automatic test_arith32();
    logic [2:0]  ops[9];
    logic [31:0] as[9], bs[9];
    logic [67:0] cst[4];
    ops = '{OP_ADD, OP_SUB, OP_SLT, OP_RSV, OP_SUB, OP_SLT, OP_SLT, OP_ADD, OP_SUB};
    as  = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h12345678, 32'd3, 32'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    bs  = '{32'd1, 32'd5, 32'd1, 32'h9ABCDEF0, 32'd5, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd1};
    cst = '{{4'b1001, 64'h80000000}, {4'b0110, 64'h0}, {4'b0010, 64'h1}, {4'b0100, 64'h0}};
    ordy32 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      iv32 = 1'b1; op32 = ops[i]; a32 = as[i]; b32 = bs[i];
      sb32.push_back((i < 4) ? cst[i] : model(32, ops[i], {32'd0, as[i]}, {32'd0, bs[i]}));
      @(negedge clk);
      iv32 = 1'b0;
      checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL arith32_valid[%0d]: got %b want 1", i, ov32); end
      exp_v = sb32.pop_front();
      checks++; if (res32 !== exp_v[31:0] || fl32 !== exp_v[67:64]) begin errors++; $display("FAIL arith32[%0d]: got %h/%b want %h/%b", i, res32, fl32, exp_v[31:0], exp_v[67:64]); end
      @(negedge clk);
      checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL arith32_drain[%0d]: got %b want 0", i, ov32); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  lops[3];
    logic [31:0] ya, yb;
    lops = '{OP_AND, OP_OR, OP_XOR};
    ordy32 = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, ov32); end
        exp_v = sb32.pop_front();
        checks++; if (res32 !== exp_v[31:0] || fl32 !== exp_v[67:64]) begin errors++; $display("FAIL b2b[%0d]: got %h/%b want %h/%b", i, res32, fl32, exp_v[31:0], exp_v[67:64]); end
      end
      if (i < 6) begin
        checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ir32); end
        iv32 = 1'b1; op32 = lops[i % 3]; a32 = $urandom(); b32 = $urandom();
        sb32.push_back(model(32, op32, {32'd0, a32}, {32'd0, b32}));
      end else begin
        iv32 = 1'b0;
      end
    end
    // Stall: hold out_ready low with a new operation waiting upstream.
    iv32 = 1'b1; op32 = OP_XOR; a32 = 32'hA5A5F00F; b32 = 32'h0F0F0F0F;
    sb32.push_back(model(32, OP_XOR, {32'd0, a32}, {32'd0, b32}));
    @(negedge clk);
    ordy32 = 1'b0; op32 = OP_AND; ya = $urandom(); yb = $urandom(); a32 = ya; b32 = yb;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (ov32 !== 1'b1 || ir32 !== 1'b0) begin errors++; $display("FAIL stall_hs[%0d]: got valid=%b ready=%b want 1/0", k, ov32, ir32); end
      checks++; if (res32 !== sb32[0][31:0] || fl32 !== sb32[0][67:64]) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%b want %h/%b", k, res32, fl32, sb32[0][31:0], sb32[0][67:64]); end
    end
    ordy32 = 1'b1;
    void'(sb32.pop_front());
    sb32.push_back(model(32, OP_AND, {32'd0, ya}, {32'd0, yb}));
    @(negedge clk);
    iv32 = 1'b0;
    exp_v = sb32.pop_front();
    checks++; if (ov32 !== 1'b1 || res32 !== exp_v[31:0] || fl32 !== exp_v[67:64]) begin errors++; $display("FAIL stall_resume: got %b %h/%b want 1 %h/%b", ov32, res32, fl32, exp_v[31:0], exp_v[67:64]); end
    @(negedge clk);
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", ov32); end
  endtask

  task automatic test_mul8();
    logic [7:0]  ma[2], mb[2];
    logic [67:0] cst[2];
    ma = '{8'hFF, 8'h10};
    mb = '{8'h00, 8'h11};
    cst = '{{4'b0100, 64'h0}, {4'b0001, 64'h10}};
    ordy8 = 1'b1;
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL mul8_accept[%0d]: got %b want 1", m, ir8); end
      iv8 = 1'b1; op8 = OP_MUL; a8 = ma[m]; b8 = mb[m];
      sb8.push_back(cst[m]);
      @(negedge clk);
      iv8 = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (k > 0) @(negedge clk);
        checks++; if (busy8 !== 1'b1 || ov8 !== 1'b0 || ir8 !== 1'b0) begin errors++; $display("FAIL mul8_run[%0d,%0d]: got busy=%b valid=%b ready=%b want 1/0/0", m, k, busy8, ov8, ir8); end
        if (m == 1 && k == 3) begin iv8 = 1'b1; op8 = OP_ADD; a8 = 8'h01; b8 = 8'h01; end
        if (m == 1 && k == 5) iv8 = 1'b0;
      end
      @(negedge clk);
      exp_v = sb8.pop_front();
      checks++; if (ov8 !== 1'b1 || busy8 !== 1'b0) begin errors++; $display("FAIL mul8_done[%0d]: got valid=%b busy=%b want 1/0", m, ov8, busy8); end
      checks++; if (res8 !== exp_v[7:0] || fl8 !== exp_v[67:64]) begin errors++; $display("FAIL mul8_result[%0d]: got %h/%b want %h/%b", m, res8, fl8, exp_v[7:0], exp_v[67:64]); end
      @(negedge clk);
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL mul8_no_extra[%0d]: got %b want 0", m, ov8); end
    end
  endtask

  task automatic test_mul32();
    logic [31:0] ma[2], mb[2];
    int cyc;
    ma = '{32'hFFFFFFFF, $urandom()};
    mb = '{32'hFFFFFFFF, $urandom()};
    ordy32 = 1'b1;
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      iv32 = 1'b1; op32 = OP_MUL; a32 = ma[m]; b32 = mb[m];
      sb32.push_back(model(32, OP_MUL, {32'd0, ma[m]}, {32'd0, mb[m]}));
      @(negedge clk);
      iv32 = 1'b0;
      cyc = 0;
      while (ov32 !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
      checks++; if (cyc !== 32) begin errors++; $display("FAIL mul32_latency[%0d]: got %0d want 32", m, cyc); end
      exp_v = sb32.pop_front();
      checks++; if (res32 !== exp_v[31:0] || fl32 !== exp_v[67:64]) begin errors++; $display("FAIL mul32_result[%0d]: got %h/%b want %h/%b", m, res32, fl32, exp_v[31:0], exp_v[67:64]); end
    end
  endtask

  task automatic test_reset_mid_mul();
    ordy8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b1; op8 = OP_MUL; a8 = 8'h23; b8 = 8'h45;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n8 = 1'b0;
    #1;
    checks++; if (ov8 !== 1'b0 || res8 !== 8'd0 || fl8 !== 4'd0 || busy8 !== 1'b0 || ir8 !== 1'b0) begin errors++; $display("FAIL midmul_reset: got v=%b r=%h f=%b busy=%b rdy=%b want all 0", ov8, res8, fl8, busy8, ir8); end
    @(negedge clk);
    rst_n8 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (ov8 !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL midmul_quiet[%0d]: got valid=%b busy=%b want 0/0", k, ov8, busy8); end
    end
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL midmul_ready: got %b want 1", ir8); end
    iv8 = 1'b1; op8 = OP_ADD; a8 = 8'hFF; b8 = 8'h01;
    sb8.push_back({4'b0110, 64'h0});
    @(negedge clk);
    iv8 = 1'b0;
    exp_v = sb8.pop_front();
    checks++; if (ov8 !== 1'b1 || res8 !== exp_v[7:0] || fl8 !== exp_v[67:64]) begin errors++; $display("FAIL midmul_add: got %b %h/%b want 1 %h/%b", ov8, res8, fl8, exp_v[7:0], exp_v[67:64]); end
  endtask

  initial begin
    test_reset();
    test_arith32();
    test_back_to_back();
    test_mul8();
    test_mul32();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the 32-bit combinational ALU.
- Adds XOR, SLT and an iterative shift-add MUL to AND/OR/ADD/SUB.
- Result and NZCV flags are registered behind valid/ready handshakes on input and output, so the block can sit between pipeline stages of the datapath.
- Flag packing matches the existing ALU: flags[3]=N, [2]=Z, [1]=C, [0]=V.

Parameters:
- WIDTH, 32: operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH): width of the MUL bit counter; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT, 110 MUL, 111 reserved.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result this cycle.
- result  out  WIDTH  registered result.
- flags  out  4  registered {N,Z,C,V}.
- busy  out  1  high while in the MUL state.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; result=0; flags=0; busy=0; counter=0.
  - in_ready is 0 while rst_n=0 and 1 from the first cycle after release.
- Handshake:
  - Accept when in_valid & in_ready at the rising edge.
  - Deliver when out_valid & out_ready.
  - in_ready = (state==IDLE) & (~out_valid | out_ready), so back-to-back single-cycle ops run at full rate.
  - While out_valid=1 and out_ready=0, result and flags hold stable.
  - out_valid drops on the edge the result is taken, unless a new result is written on the same edge.
- States: IDLE, MUL.
- IDLE, on accepting a single-cycle op (AND/OR/ADD/SUB/XOR/SLT/111):
  - Result and flags are written on the accept edge; out_valid=1 the next cycle (latency 1).
  - State stays IDLE.
- IDLE, on accepting MUL:
  - Latch a into a 2*WIDTH multiplicand register (zero-extended) and b into a multiplier shift register.
  - Clear the 2*WIDTH accumulator, set counter=0, go to MUL; busy=1.
- MUL, once per cycle:
  - If multiplier[0]=1, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1; increment counter.
  - On the cycle counter==WIDTH-1: write result = acc[WIDTH-1:0] (including the last partial add), set out_valid=1, return to IDLE.
  - out_valid therefore rises WIDTH cycles after the accept edge.
  - MUL is only entered when the output register is free or draining, so the write never overruns.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: a+b; C=carry-out; V=signed overflow (operands same sign, result sign differs).
  - SUB: a+~b+1; C=carry-out (1 = no borrow); V=signed overflow (operands differ in sign, result sign differs from a).
  - SLT: result = {0…0, signed(a)<signed(b)}, computed as N_sub ^ V_sub; C and V are taken from the subtraction.
  - AND/OR/XOR: C=0, V=0.
  - MUL: unsigned low half; C=0; V = |acc[2*WIDTH-1:WIDTH] (upper half non-zero).
  - Reserved op 111: result=0, flags = {0,1,0,0}.
  - All ops: N=result[WIDTH-1]; Z = (result==0).
- Boundaries:
  - A MUL with b=0 still takes WIDTH cycles; no early exit.
  - in_valid during MUL is ignored (in_ready=0); the upstream must hold its operands.
  - The counter stops at WIDTH-1; there is no wrap.
  - An async reset mid-MUL aborts the operation and discards partial state; no out_valid pulse follows.
  - If out_ready rises on the same edge MUL completes, the new result is registered and the old one is consumed.

Decomposition:
- Package alu_pkg:
  - op localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SLT, OP_MUL.
  - flag index localparams: FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
  - state enum {S_IDLE, S_MUL}.
- One sub-module, alu_addsub_core #(WIDTH): combinational a, b, sub → sum, cout, ovf. It is shared by ADD, SUB and SLT.
- The MUL accumulator uses its own 2*WIDTH adder.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF, b=1 → one cycle later result=0x80000000, flags=4'b1001 (N,V).
- WIDTH=32, SUB a=5, b=5 → result=0, flags=4'b0110 (Z,C). Then SLT a=0xFFFFFFFF (−1), b=1 → result=1, flags=4'b0010 (C=1 from the subtraction).
- WIDTH=8, MUL a=0x10, b=0x11:
  - busy=1 for 8 cycles; out_valid rises 8 cycles after accept.
  - result=0x10, V=1 (product 0x110).
  - in_ready=0 throughout; an in_valid pulse mid-MUL is not accepted.
- WIDTH=32, back-to-back AND/OR/XOR with out_ready=1 → one result per cycle. With out_ready held 0 for 3 cycles, result and flags stay stable, in_ready=0, and no result is lost.
- WIDTH=8, rst_n driven low 3 cycles into a MUL, then released:
  - out_valid=0, result=0, flags=0, state IDLE.
  - A new ADD 0xFF+0x01 then gives result=0x00, flags=4'b0110.
